// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer borrowing the shared ALU for add/sub.
// Optional macro MULDIV_ZERO_SKIP_EN: multiplies with a zero operand finish early from PREP.
module muldiv_seq #(
    parameter int D_WIDTH = 32,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [D_WIDTH-1:0] rs1,
    input  logic [D_WIDTH-1:0] rs2,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] result,
    output logic [D_WIDTH-1:0] alu_op1,
    output logic [D_WIDTH-1:0] alu_op2,
    output logic [3:0]         alu_ctrl,
    input  logic [D_WIDTH-1:0] alu_out
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0]         ALU_ADD = 4'b0000;
    localparam logic [3:0]         ALU_SUB = 4'b0001;
    localparam logic [D_WIDTH-1:0] ZERO    = '0;
    localparam logic [D_WIDTH-1:0] ONES    = '1;
    localparam logic [D_WIDTH-1:0] MIN_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(D_WIDTH - 1);

    logic [2:0]           state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [D_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [D_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [D_WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;

    logic                 is_div, is_rem, signed_a, signed_b, sa, sb, carry, take;
    logic [D_WIDTH-1:0]   a_mag, b_mag, sum, rem_s, quo_fix, rem_fix;
    logic [2*D_WIDTH-1:0] prod_fix;

    // NOTE: every combinational output gets a default at the top so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        alu_op1  = ZERO;
        alu_op2  = ZERO;
        alu_ctrl = ALU_ADD;

        is_div   = op_q[2];
        is_rem   = op_q[2] & op_q[1];
        // Signed A: MULH, MULHSU, DIV, REM. Signed B: MULH, DIV, REM. MUL low half is sign-agnostic.
        signed_a = op_q[2] ? ~op_q[0] : (op_q == 3'b001 || op_q == 3'b010);
        signed_b = op_q[2] ? ~op_q[0] : (op_q == 3'b001);
        sa       = signed_a & a_q[D_WIDTH-1];
        sb       = signed_b & b_q[D_WIDTH-1];
        a_mag    = sa ? -a_q : a_q;
        b_mag    = sb ? -b_q : b_q;

        sum      = hi_q;
        carry    = 1'b0;
        rem_s    = {hi_q[D_WIDTH-2:0], lo_q[D_WIDTH-1]};
        take     = 1'b0;

        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_fix  = neg_q ? -lo_q : lo_q;
        rem_fix  = neg_q ? -hi_q : hi_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = rs1;
                    b_d     = rs2;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                a_d   = a_mag;
                b_d   = b_mag;
                hi_d  = ZERO;
                lo_d  = is_div ? a_mag : b_mag;
                cnt_d = '0;
                neg_d = is_rem ? sa : (sa ^ sb);
                if (is_div && b_q == ZERO) begin
                    result_d = is_rem ? a_q : ONES;
                    state_d  = S_DONE;
                end else if (is_div && !op_q[0] && a_q == MIN_NEG && b_q == ONES) begin
                    result_d = is_rem ? ZERO : MIN_NEG;
                    state_d  = S_DONE;
`ifdef MULDIV_ZERO_SKIP_EN
                end else if (!is_div && (a_q == ZERO || b_q == ZERO)) begin
                    result_d = ZERO;
                    state_d  = S_DONE;
`endif
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
                if (!is_div) begin
                    if (lo_q[0]) begin
                        alu_op1  = hi_q;
                        alu_op2  = a_q;
                        alu_ctrl = ALU_ADD;
                        sum      = alu_out;
                        carry    = (alu_out < hi_q);
                    end
                    hi_d = {carry, sum[D_WIDTH-1:1]};
                    lo_d = {sum[0], lo_q[D_WIDTH-1:1]};
                end else begin
                    alu_op1  = rem_s;
                    alu_op2  = b_q;
                    alu_ctrl = ALU_SUB;
                    // hi_q[MSB] is the bit shifted out of rem, i.e. bit 32 of the shifted remainder.
                    take     = hi_q[D_WIDTH-1] | (rem_s >= b_q);
                    hi_d     = take ? alu_out : rem_s;
                    lo_d     = {lo_q[D_WIDTH-2:0], take};
                end
            end
            S_FIX: begin
                if (!is_div)
                    result_d = (op_q == 3'b000) ? prod_fix[D_WIDTH-1:0] : prod_fix[2*D_WIDTH-1:D_WIDTH];
                else
                    result_d = op_q[1] ? rem_fix : quo_fix;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 3'b000;
            a_q      <= ZERO;
            b_q      <= ZERO;
            hi_q     <= ZERO;
            lo_q     <= ZERO;
            result_q <= ZERO;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural add/sub ALU model.
// Latency is counted as the cycle index after the start-sampling edge (PREP = cycle 1).
module tb_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] rs1 = '0;
    logic [W-1:0] rs2 = '0;
    logic         busy, done;
    logic [W-1:0] result, alu_op1, alu_op2, alu_out;
    logic [3:0]   alu_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign alu_out = (alu_ctrl == 4'b0001) ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

    muldiv_seq #(.D_WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .busy(busy), .done(done), .result(result),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl), .alu_out(alu_out)
    );

    // Issues one operation and returns result, latency (-1 on timeout) and ALU usage flags.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int lat,
                          output logic saw_sub, output logic saw_bad_ctrl);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        saw_sub = 1'b0;
        saw_bad_ctrl = 1'b0;
        while (!done && cyc < 100) begin
            if (alu_ctrl == 4'b0001) saw_sub = 1'b1;
            if (alu_ctrl != 4'b0000 && alu_ctrl != 4'b0001) saw_bad_ctrl = 1'b1;
            @(negedge clk);
            cyc++;
        end
        res = result;
        lat = done ? cyc : -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL reset_flags: got busy/done %b expected 00", {busy, done});
        end
        n_cmp++;
        if (result !== '0) begin
            n_bad++; $display("FAIL reset_result: got %h expected 0", result);
        end
        n_cmp++;
        if ({alu_op1, alu_op2, alu_ctrl} !== '0) begin
            n_bad++; $display("FAIL reset_alu: got %h %h %b expected zeros", alu_op1, alu_op2, alu_ctrl);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multiply();
        logic [2:0]   ops [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        logic [W-1:0] as  [4] = '{32'h0000_0007, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [W-1:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0002};
        logic [W-1:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
        logic [W-1:0] res;
        int lat;
        logic ss, sb;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, ss, sb);
            n_cmp++;
            if (res !== exp[i]) begin
                n_bad++; $display("FAIL mul_result[%0d]: got %h expected %h", i, res, exp[i]);
            end
            n_cmp++;
            if (lat != 35) begin
                n_bad++; $display("FAIL mul_latency[%0d]: got %0d expected 35", i, lat);
            end
            n_cmp++;
            if ({ss, sb} !== 2'b00) begin
                n_bad++; $display("FAIL mul_alu_ctrl[%0d]: got sub/bad %b expected 00", i, {ss, sb});
            end
            @(negedge clk);
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_bad++; $display("FAIL mul_idle_after[%0d]: got busy/done %b expected 00", i, {busy, done});
            end
        end
    endtask

    task automatic test_divide();
        logic [2:0]   ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [W-1:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [W-1:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [W-1:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [W-1:0] res;
        int lat;
        logic ss, sb;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, ss, sb);
            n_cmp++;
            if (res !== exp[i]) begin
                n_bad++; $display("FAIL div_result[%0d]: got %h expected %h", i, res, exp[i]);
            end
            n_cmp++;
            if (lat != 35) begin
                n_bad++; $display("FAIL div_latency[%0d]: got %0d expected 35", i, lat);
            end
            n_cmp++;
            if ({ss, sb} !== 2'b10) begin
                n_bad++; $display("FAIL div_alu_ctrl[%0d]: got sub/bad %b expected 10", i, {ss, sb});
            end
        end
    endtask

    task automatic test_div_edge();
        logic [2:0]   ops [5] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b110};
        logic [W-1:0] as  [5] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB};
        logic [W-1:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [W-1:0] exp [5] = '{32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'd0, 32'hFFFF_FFFB};
        logic [W-1:0] res;
        int lat;
        logic ss, sb;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, ss, sb);
            n_cmp++;
            if (res !== exp[i]) begin
                n_bad++; $display("FAIL edge_result[%0d]: got %h expected %h", i, res, exp[i]);
            end
            n_cmp++;
            if (lat != 2) begin
                n_bad++; $display("FAIL edge_latency[%0d]: got %0d expected 2", i, lat);
            end
        end
    endtask

    task automatic test_zero_mul();
        logic [W-1:0] res;
        int lat;
        int exp_lat;
        logic ss, sb;
`ifdef MULDIV_ZERO_SKIP_EN
        exp_lat = 2;
`else
        exp_lat = 35;
`endif
        run_op(3'b000, 32'd0, 32'd123, res, lat, ss, sb);
        n_cmp++;
        if (res !== 32'd0) begin
            n_bad++; $display("FAIL zero_mul_result: got %h expected 0", res);
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_bad++; $display("FAIL zero_mul_latency: got %0d expected %0d", lat, exp_lat);
        end
        run_op(3'b011, 32'd5, 32'd0, res, lat, ss, sb);
        n_cmp++;
        if (res !== 32'd0 || lat != exp_lat) begin
            n_bad++; $display("FAIL zero_mulhu: got %h lat %0d expected 0 lat %0d", res, lat, exp_lat);
        end
    endtask

    task automatic test_start_ignored();
        int ndone;
        logic [W-1:0] res;
        @(negedge clk);
        start = 1'b1; op = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        ndone = 0;
        res = '0;
        for (int c = 1; c <= 80; c++) begin
            if (done) begin
                ndone++;
                res = result;
            end
            start = (c >= 3 && c <= 5);
            if (start) begin
                op = 3'b000; rs1 = 32'd2; rs2 = 32'd3;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (ndone != 1) begin
            n_bad++; $display("FAIL ignore_start_count: got %0d dones expected 1", ndone);
        end
        n_cmp++;
        if (res !== 32'd14) begin
            n_bad++; $display("FAIL ignore_start_result: got %h expected %h", res, 32'd14);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] res;
        int lat;
        logic ss, sb;
        @(negedge clk);
        start = 1'b1; op = 3'b000; rs1 = 32'd3; rs2 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_busy_before_reset: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00 || result !== '0) begin
            n_bad++; $display("FAIL mid_reset_outputs: got busy/done %b result %h expected 00 0", {busy, done}, result);
        end
        n_cmp++;
        if ({alu_op1, alu_op2, alu_ctrl} !== '0) begin
            n_bad++; $display("FAIL mid_reset_alu: got %h %h %b expected zeros", alu_op1, alu_op2, alu_ctrl);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_no_done: got %b expected 0", done);
        end
        rst_n = 1'b1;
        run_op(3'b000, 32'd3, 32'd5, res, lat, ss, sb);
        n_cmp++;
        if (res !== 32'd15 || lat != 35) begin
            n_bad++; $display("FAIL mid_reset_rerun: got %h lat %0d expected %h lat 35", res, lat, 32'd15);
        end
    endtask

    task automatic test_back_to_back();
        int first, second, guard;
        logic [W-1:0] r1, r2;
        first = -1; second = -1; r1 = '0; r2 = '0;
        @(negedge clk);
        start = 1'b1; op = 3'b111; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                if (first < 0) begin
                    first = c; r1 = result;
                end else if (second < 0) begin
                    second = c; r2 = result;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (first != 35 || r1 !== 32'd2) begin
            n_bad++; $display("FAIL b2b_first: got cycle %0d result %h expected 35 %h", first, r1, 32'd2);
        end
        n_cmp++;
        if (second != 71 || r2 !== 32'd2) begin
            n_bad++; $display("FAIL b2b_second: got cycle %0d result %h expected 71 %h", second, r2, 32'd2);
        end
        guard = 0;
        while (busy && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_drain: got busy %b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_edge();
        test_zero_mul();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle RV32M multiply/divide sequencer.
- Drives the shared 32-bit integer ALU through its operand and control inputs for one add or subtract per cycle, and performs all shifting, sign handling and result selection locally.
- Sits beside the execute stage; the pipeline stalls on busy and captures result on done.

Parameters:
D_WIDTH, 32, operand/result width; iteration count = D_WIDTH
CNT_W, 6, width of the iteration counter; must hold D_WIDTH

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  request; sampled only in IDLE
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  in  D_WIDTH  operand A (multiplicand/dividend)
rs2  in  D_WIDTH  operand B (multiplier/divisor)
busy  out  1  high from cycle after accepted start until done cycle inclusive
done  out  1  one-cycle pulse; result valid only when done=1
result  out  D_WIDTH  final value; holds until next accepted start
alu_op1  out  D_WIDTH  to ALU aluop1
alu_op2  out  D_WIDTH  to ALU aluop2
alu_ctrl  out  4  to ALU; 4'b0000 add, 4'b0001 sub only
alu_out  in  D_WIDTH  from ALU, combinational same cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, alu_op1=0, alu_op2=0, alu_ctrl=0, counter=0. Reset mid-operation aborts; no done is produced.
- States: IDLE -> PREP -> ITER (D_WIDTH cycles) -> FIX -> DONE -> IDLE.
- IDLE: on start=1, latch op, rs1 and rs2, then go to PREP. start is ignored in every other state.
- PREP (1 cycle):
  - Operand magnitudes: signed ops take |A| and |B| (MULHSU: A signed, B unsigned).
  - Record the result sign: MUL*/DIV use signA^signB; REM uses signA.
  - Clear the accumulator and set counter=0.
  - Early-out: divide ops with B==0, or DIV/REM with A==0x80000000 and B==0xFFFFFFFF, go directly to DONE.
- ITER multiply, shift-add on 64-bit {hi,lo}, lo initialised to |B|:
  - When lo[0]=1: alu_ctrl=add, alu_op1=hi, alu_op2=|A|; carry = (alu_out < hi).
  - Then {hi,lo} = {carry, sum_or_hi, lo} >> 1.
- ITER divide, restoring, {rem,quot} with quot initialised to |A|:
  - Shift left by 1; the shifted-out rem MSB is kept as bit 32.
  - alu_ctrl=sub, alu_op1=rem, alu_op2=|B|.
  - When bit32=1 or rem >= |B| (local unsigned compare): rem=alu_out and quot LSB=1.
- In ITER, counter increments each cycle; leave ITER when counter == D_WIDTH-1.
- Outside ITER, alu_op1, alu_op2 and alu_ctrl are driven to 0 (the ALU output is ignored).
- FIX (1 cycle):
  - Conditional two's-complement negation, computed locally and 64-bit for multiply.
  - Select the result: MUL = lo; MULH/MULHSU/MULHU = hi; DIV/DIVU = quot; REM/REMU = rem.
- DONE: done=1, busy=1, result registered; return to IDLE next cycle. busy=0 and done=0 in IDLE.
- Latency:
  - Normal: done asserted D_WIDTH+3 cycles after the start-sampling edge (35 for D_WIDTH=32).
  - Early-out: 2 cycles.
- Early-out results:
  - Divide by zero: quotient = all-ones, remainder = A.
  - Overflow: quotient = 0x80000000, remainder = 0.
- start held high continuously: a new operation is accepted in the IDLE cycle after DONE.

Optional Feature:
- Macro MULDIV_ZERO_SKIP_EN.
- Defined: a multiply with rs1==0 or rs2==0 is detected in PREP and goes straight to DONE with result=0 (latency 2, ALU untouched).
- Undefined: zero operands run the full D_WIDTH iterations and produce result 0 at normal latency.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> done at cycle 35, result=0xFFFFFFEB; alu_ctrl only ever 0000 during ITER.
- MULH rs1=rs2=0x80000000 -> result=0x40000000; MULHU same operands -> 0x40000000; MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 100/0 -> 0xFFFFFFFF, REMU 100/0 -> 100, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0; all with done 2 cycles after start.
- start pulsed again during busy -> ignored, exactly one done; rst_n low at ITER cycle 10 -> busy=0, done=0 and all outputs 0 immediately, then a new MUL 3*5=15 completes normally.
- With MULDIV_ZERO_SKIP_EN: MUL 0*123 -> result 0 at latency 2; without it -> result 0 at latency 35.
